// File: rtl/therm_sample_ctrl.sv
// Thermistor sampling sequencer: periodic ADC start, ADC-done capture with timeout,
// converter handshake and publish. Define THERM_SAMPLE_AVG_EN to average four ADC samples.
module therm_sample_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] period,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [3:0]  adc_code,
  output logic        conv_req,
  output logic [3:0]  conv_code,
  input  logic        conv_ack,
  input  logic [31:0] conv_temp,
  output logic [31:0] temp_out,
  output logic        temp_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TICK = 3'd1;
  localparam logic [2:0] S_ADC_REQ   = 3'd2;
  localparam logic [2:0] S_ADC_WAIT  = 3'd3;
  localparam logic [2:0] S_CONV_REQ  = 3'd4;
  localparam logic [2:0] S_PUBLISH   = 3'd5;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [15:0] r_tick;
  logic [15:0] r_to_cnt;
  logic [3:0]  r_conv_code;
  logic [31:0] r_temp;
  logic        r_timeout_err;
  logic [15:0] w_reload;
  logic [15:0] w_tick_dec;

  // Valid/ready: adc_start is a one-cycle pulse answered by a single adc_done strobe while
  // waiting; conv_req is a level held with a stable conv_code until the cycle conv_ack is seen.
  assign w_reload   = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign w_tick_dec = (r_tick == 16'd0) ? 16'd0 : r_tick - 16'd1;

`ifdef THERM_SAMPLE_AVG_EN
  logic [1:0] r_smp_idx;
  logic [5:0] r_acc;
  logic [5:0] w_acc_sum;
  assign w_acc_sum = r_acc + {2'b00, adc_code};
`endif

  // The tick counter free-runs down through the whole sample so that the next start is
  // measured from the previous ADC_REQ; PUBLISH and a timeout fall back into that count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_tick        <= 16'd0;
      r_to_cnt      <= 16'd0;
      r_conv_code   <= 4'd0;
      r_temp        <= 32'd0;
      r_timeout_err <= 1'b0;
`ifdef THERM_SAMPLE_AVG_EN
      r_smp_idx     <= 2'd0;
      r_acc         <= 6'd0;
`endif
    end else begin
      r_tick <= w_tick_dec;
      case (r_state)
        S_IDLE: begin
`ifdef THERM_SAMPLE_AVG_EN
          r_smp_idx <= 2'd0;
          r_acc     <= 6'd0;
`endif
          if (enable) begin
            r_tick        <= w_reload;
            r_timeout_err <= 1'b0;
            r_state       <= S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_tick == 16'd0) begin
            r_tick  <= w_reload;
            r_state <= S_ADC_REQ;
          end
        end
        S_ADC_REQ: begin
          r_to_cnt <= 16'd0;
          r_state  <= enable ? S_ADC_WAIT : S_IDLE;
        end
        S_ADC_WAIT: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (adc_done) begin
`ifdef THERM_SAMPLE_AVG_EN
            if (r_smp_idx == 2'd3) begin
              r_conv_code <= w_acc_sum[5:2];
              r_acc       <= 6'd0;
              r_smp_idx   <= 2'd0;
              r_state     <= S_CONV_REQ;
            end else begin
              r_acc     <= w_acc_sum;
              r_smp_idx <= r_smp_idx + 2'd1;
              r_state   <= S_ADC_REQ;
            end
`else
            r_conv_code <= adc_code;
            r_state     <= S_CONV_REQ;
`endif
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_WAIT_TICK;
`ifdef THERM_SAMPLE_AVG_EN
            r_acc     <= 6'd0;
            r_smp_idx <= 2'd0;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_CONV_REQ: begin
          if (conv_ack) begin
            r_temp  <= conv_temp;
            r_state <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_tick == 16'd0) begin
            r_tick  <= w_reload;
            r_state <= S_ADC_REQ;
          end else begin
            r_state <= S_WAIT_TICK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adc_start   = (r_state == S_ADC_REQ);
  assign conv_req    = (r_state == S_CONV_REQ);
  assign temp_valid  = (r_state == S_PUBLISH);
  assign busy        = (r_state != S_IDLE) && (r_state != S_WAIT_TICK);
  assign conv_code   = r_conv_code;
  assign temp_out    = r_temp;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_therm_sample_ctrl.sv
// Directed bench for therm_sample_ctrl: vector table of complete samples plus hand
// sequences for period spacing, ADC timeout, late disable and asynchronous reset.
module tb_therm_sample_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] period;
  logic        adc_start;
  logic        adc_done;
  logic [3:0]  adc_code;
  logic        conv_req;
  logic [3:0]  conv_code;
  logic        conv_ack;
  logic [31:0] conv_temp;
  logic [31:0] temp_out;
  logic        temp_valid;
  logic        busy;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  therm_sample_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .adc_start(adc_start), .adc_done(adc_done), .adc_code(adc_code),
    .conv_req(conv_req), .conv_code(conv_code), .conv_ack(conv_ack), .conv_temp(conv_temp),
    .temp_out(temp_out), .temp_valid(temp_valid), .busy(busy),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: run still active, want finished");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int start_q[$];
  int tv_cnt = 0;

  // responder settings written by the main sequence
  logic [3:0]  codes[4];
  int          adc_dly = 0;
  int          ack_dly = 0;
  logic [31:0] cur_temp = 32'd0;
  logic [3:0]  exp_code = 4'd0;
  logic        stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return adc_start;
      1:       return conv_req;
      default: return temp_valid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max_cyc, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sig_of(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got no pulse within %0d cycles want pulse", name, max_cyc);
    end
  endtask

  task automatic set_codes(input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
    codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
  endtask

  // ADC model: one adc_done strobe adc_dly cycles after each adc_start (never when 0)
  initial begin
    int cnt;
    int idx;
    cnt = -1;
    idx = 0;
    adc_done = 1'b0;
    adc_code = 4'd0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (dbg_state == ST_IDLE) idx = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          adc_done = 1'b1;
          adc_code = codes[idx % 4];
          idx++;
          cnt = -1;
        end
      end
      if (adc_start) begin
        start_q.push_back(cyc);
        if (adc_dly > 0) cnt = adc_dly;
      end
    end
  end

  // converter model: conv_ack ack_dly cycles after conv_req rises; conv_code checked while waiting
  initial begin
    int cnt;
    cnt = 0;
    conv_ack  = 1'b0;
    conv_temp = 32'd0;
    forever begin
      @(negedge clk);
      conv_ack = 1'b0;
      if (stray_ack) begin
        conv_ack  = 1'b1;
        conv_temp = 32'h5555_AAAA;
      end else if (conv_req) begin
        cnt++;
        check("conv_code_held", {28'd0, conv_code}, {28'd0, exp_code});
        if (cnt > ack_dly) begin
          conv_ack  = 1'b1;
          conv_temp = cur_temp;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // scoreboard: each temp_valid pulse must match the next expected temperature
  initial forever begin
    @(negedge clk);
    if (temp_valid) begin
      tv_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("sb_temp_out", temp_out, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [15:0] period;
    logic [3:0]  code;
    int          adc_dly;
    int          ack_dly;
    logic [31:0] temp;
    logic [3:0]  exp_code;
    logic [31:0] exp_temp;
  } vec_t;

  vec_t tab[5];

  initial begin
    bit ok;
    int e;
    int n0;
    int s0;
    logic flag;
    logic seen_conv;

    tab[0] = '{16'd10,  4'd9,  3, 5, 32'd298,      4'd9,  32'd298};
    tab[1] = '{16'd0,   4'd0,  1, 0, 32'h0000_0001, 4'd0,  32'h0000_0001};
    tab[2] = '{16'd3,   4'd15, 2, 1, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFF};
    tab[3] = '{16'd1,   4'd6,  5, 3, 32'h8000_0000, 4'd6,  32'h8000_0000};
    tab[4] = '{16'd200, 4'd10, 4, 2, 32'h1234_5678, 4'd10, 32'h1234_5678};

    rst_n  = 1'b0;
    enable = 1'b0;
    period = 16'd0;
    set_codes(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("rst_adc_start", {31'd0, adc_start}, 32'd0);
    check("rst_conv_req", {31'd0, conv_req}, 32'd0);
    check("rst_conv_code", {28'd0, conv_code}, 32'd0);
    check("rst_temp_out", temp_out, 32'd0);
    check("rst_flags", {29'd0, temp_valid, busy, timeout_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // table of complete samples; enable drops on the publish cycle so each run ends in IDLE
    for (int i = 0; i < 5; i++) begin
      period   = tab[i].period;
      set_codes(tab[i].code, tab[i].code, tab[i].code, tab[i].code);
      adc_dly  = tab[i].adc_dly;
      ack_dly  = tab[i].ack_dly;
      cur_temp = tab[i].temp;
      exp_code = tab[i].exp_code;
      exp_q.push_back(tab[i].exp_temp);
      enable = 1'b1;
      wait_for(2, 500, "vec_temp_valid", ok);
      enable = 1'b0;
      @(negedge clk);
      check("vec_idle_after", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("vec_busy_after", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("vec_temp_hold", temp_out, tab[i].exp_temp);
    end

    // conv_ack while idle is ignored
    @(posedge clk);
    stray_ack = 1'b1;
    @(posedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_temp", temp_out, 32'h1234_5678);
    check("stray_ack_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

`ifdef THERM_SAMPLE_AVG_EN
    // four samples 15,14,13,12 sum to 54; 54>>2 = 13
    period = 16'd10;
    set_codes(4'd15, 4'd14, 4'd13, 4'd12);
    adc_dly = 2; ack_dly = 1; cur_temp = 32'd333; exp_code = 4'd13;
    exp_q.push_back(32'd333);
    enable = 1'b1;
    wait_for(2, 300, "avg_temp_valid", ok);
    enable = 1'b0;
    @(negedge clk);
    check("avg_conv_code", {28'd0, conv_code}, 32'd13);
    e = 30;
`else
    e = 10;
`endif

    // starts period cycles apart; first start period+1 cycles after enable
    period = 16'(e);
    set_codes(4'd7, 4'd7, 4'd7, 4'd7);
    adc_dly = 3; ack_dly = 2; cur_temp = 32'd300; exp_code = 4'd7;
    repeat (3) exp_q.push_back(32'd300);
    start_q.delete();
    s0 = cyc;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(2, 200, "spacing_temp_valid", ok);
    end
    enable = 1'b0;
    @(negedge clk);
    check("spacing_count", start_q.size(), 32'd3);
    if (start_q.size() >= 3) begin
      check("spacing_first", start_q[0] - s0, e + 1);
      check("spacing_1", start_q[1] - start_q[0], e);
      check("spacing_2", start_q[2] - start_q[1], e);
    end

    // ADC timeout: flag after 8 silent ADC_WAIT cycles, next start still period after previous
    period = 16'd20;
    adc_dly = 0;
    enable = 1'b1;
    wait_for(0, 100, "to_first_start", ok);
    s0 = cyc;
    flag = 1'b0;
    seen_conv = 1'b0;
    repeat (7) begin
      @(negedge clk);
      flag = flag | timeout_err;
      seen_conv = seen_conv | conv_req;
    end
    check("to_not_early", {31'd0, flag}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      seen_conv = seen_conv | conv_req;
    end
    check("to_flag_set", {31'd0, timeout_err}, 32'd1);
    check("to_back_to_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    wait_for(0, 40, "to_next_start", ok);
    check("to_next_start_gap", cyc - s0, 32'd20);
    check("to_no_conv_req", {31'd0, seen_conv}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check("to_disable_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("to_flag_sticky", {31'd0, timeout_err}, 32'd1);
    enable = 1'b1;
    @(negedge clk);
    check("to_flag_cleared", {31'd0, timeout_err}, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // enable dropped while conv_req high: handshake completes, publish, then idle
    period = 16'd10;
    set_codes(4'd11, 4'd11, 4'd11, 4'd11);
    adc_dly = 2; ack_dly = 4; cur_temp = 32'hCAFE_0029; exp_code = 4'd11;
    exp_q.push_back(32'hCAFE_0029);
    n0 = tv_cnt;
    enable = 1'b1;
    wait_for(1, 300, "late_conv_req", ok);
    enable = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (temp_valid) break;
      if (!conv_req) flag = 1'b1;
    end
    check("late_req_held", {31'd0, flag}, 32'd0);
    @(negedge clk);
    check("late_one_valid", tv_cnt - n0, 32'd1);
    check("late_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    n0 = start_q.size();
    repeat (20) @(negedge clk);
    check("late_no_start", start_q.size() - n0, 32'd0);

    // asynchronous reset in the middle of the converter handshake
    period = 16'd5;
    set_codes(4'd4, 4'd4, 4'd4, 4'd4);
    adc_dly = 1; ack_dly = 1000; cur_temp = 32'd1; exp_code = 4'd4;
    enable = 1'b1;
    wait_for(1, 100, "rst_conv_req_seen", ok);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_conv_req", {31'd0, conv_req}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_temp_out", temp_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
